uart_rx: RTL and testbench

- UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity.
- Receive-side counterpart of the team's UART transmitter; shares the same CLKS_PER_BIT convention.
- Synchronises the asynchronous serial line and samples each bit at its midpoint.
- Presents each received byte with a one-cycle valid strobe; flags bad stop bits as framing errors.

---
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling behind a two-flop synchroniser.
// Emits a one-cycle valid strobe per good byte and a one-cycle framing-error strobe.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Framing_Err,
  output logic       o_Rx_Active
);

  localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned LAST = CLKS_PER_BIT - 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_e;

  state_e      state_q;
  logic        rx_meta_q;
  logic        rx_sync_q;
  logic [31:0] clk_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        err_q;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q          <= IDLE;
      clk_cnt_q        <= 32'd0;
      bit_idx_q        <= 3'd0;
      shift_q          <= 8'h00;
      err_q            <= 1'b0;
      o_Rx_DV          <= 1'b0;
      o_Rx_Byte        <= 8'h00;
      o_Rx_Framing_Err <= 1'b0;
      o_Rx_Active      <= 1'b0;
    end else begin
      o_Rx_DV          <= 1'b0;
      o_Rx_Framing_Err <= 1'b0;
      case (state_q)
        IDLE: begin
          clk_cnt_q   <= 32'd0;
          bit_idx_q   <= 3'd0;
          o_Rx_Active <= 1'b0;
          if (!rx_sync_q) begin
            state_q     <= START;
            o_Rx_Active <= 1'b1;
          end
        end
        START: begin
          o_Rx_Active <= 1'b1;
          if (clk_cnt_q == 32'(HALF)) begin
            clk_cnt_q <= 32'd0;
            if (!rx_sync_q) begin
              state_q <= DATA;
            end else begin
              state_q     <= IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        DATA: begin
          if (clk_cnt_q == 32'(LAST)) begin
            clk_cnt_q          <= 32'd0;
            shift_q[bit_idx_q] <= rx_sync_q;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= 3'd0;
              state_q   <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        STOP: begin
          if (clk_cnt_q == 32'(LAST)) begin
            clk_cnt_q   <= 32'd0;
            o_Rx_Active <= 1'b0;
            state_q     <= CLEANUP;
            if (rx_sync_q) begin
              o_Rx_Byte <= shift_q;
              o_Rx_DV   <= 1'b1;
              err_q     <= 1'b0;
            end else begin
              o_Rx_Framing_Err <= 1'b1;
              err_q            <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        CLEANUP: begin
          // After a framing error wait for the line to go high so a break is not a new start bit.
          if (!err_q || rx_sync_q) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          clk_cnt_q   <= 32'd0;
          bit_idx_q   <= 3'd0;
          err_q       <= 1'b0;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: three instances at 4, 8 and 16 clocks per bit,
// table-driven single frames plus hand-written corner-case sequences.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx  = 3'b111;
  logic [2:0] dv;
  logic [2:0] fe;
  logic [2:0] act;
  logic [7:0] rx_byte [3];

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(4)) u_rx4 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]),
    .o_Rx_Byte(rx_byte[0]), .o_Rx_Framing_Err(fe[0]), .o_Rx_Active(act[0]));
  uart_rx #(.CLKS_PER_BIT(8)) u_rx8 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]),
    .o_Rx_Byte(rx_byte[1]), .o_Rx_Framing_Err(fe[1]), .o_Rx_Active(act[1]));
  uart_rx #(.CLKS_PER_BIT(16)) u_rx16 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]),
    .o_Rx_Byte(rx_byte[2]), .o_Rx_Framing_Err(fe[2]), .o_Rx_Active(act[2]));

  // Pulse monitor, sampled on the falling edge
  int         dv_cnt  [3] = '{0, 0, 0};
  int         fe_cnt  [3] = '{0, 0, 0};
  int         act_cyc [3] = '{0, 0, 0};
  logic [7:0] last_b  [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] prev_b  [3] = '{8'h00, 8'h00, 8'h00};
  time        dv_t    [3] = '{0, 0, 0};
  int         bad_excl  = 0;
  int         bad_width = 0;
  logic [2:0] dv_prev   = 3'b000;
  logic [2:0] fe_prev   = 3'b000;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i] === 1'b1) begin
        dv_cnt[i]++;
        prev_b[i] = last_b[i];
        last_b[i] = rx_byte[i];
        dv_t[i]   = $time;
      end
      if (fe[i] === 1'b1) fe_cnt[i]++;
      if (act[i] === 1'b1) act_cyc[i]++;
      if (dv[i] === 1'b1 && fe[i] === 1'b1) bad_excl++;
      if ((dv[i] === 1'b1 && dv_prev[i]) || (fe[i] === 1'b1 && fe_prev[i])) bad_width++;
    end
    dv_prev = dv;
    fe_prev = fe;
  end

  int  n_checks = 0;
  int  n_fail   = 0;
  time start_t  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drives one frame on line sel; align=0 starts at once (back-to-back with the previous stop bit).
  task automatic send_frame(input int sel, input int clks, input logic [7:0] d,
                            input logic stop_b, input logic align);
    if (align) @(negedge clk);
    start_t = $time;
    rx[sel] = 1'b0;
    repeat (clks) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx[sel] = d[b];
      repeat (clks) @(negedge clk);
    end
    rx[sel] = stop_b;
    repeat (clks) @(negedge clk);
  endtask

  typedef struct {
    int         sel;
    int         clks;
    logic [7:0] data;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  int         s, d0, f0, a0, lat;
  logic [7:0] pat;

  initial begin
    vecs[0] = '{0,  4, 8'hA5, 1, 0, 8'hA5};
    vecs[1] = '{0,  4, 8'h00, 1, 0, 8'h00};
    vecs[2] = '{0,  4, 8'hFF, 1, 0, 8'hFF};
    vecs[3] = '{1,  8, 8'h5A, 1, 0, 8'h5A};
    vecs[4] = '{2, 15, 8'hC3, 1, 0, 8'hC3};
    vecs[5] = '{2, 17, 8'hC3, 1, 0, 8'hC3};
    vecs[6] = '{2, 16, 8'h96, 1, 0, 8'h96};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_dv%0d", i), 32'(dv[i]), 32'd0);
      check($sformatf("reset_fe%0d", i), 32'(fe[i]), 32'd0);
      check($sformatf("reset_act%0d", i), 32'(act[i]), 32'd0);
      check($sformatf("reset_byte%0d", i), 32'(rx_byte[i]), 32'h00);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table-driven single frames
    for (int v = 0; v < NV; v++) begin
      s  = vecs[v].sel;
      d0 = dv_cnt[s];
      f0 = fe_cnt[s];
      a0 = act_cyc[s];
      send_frame(s, vecs[v].clks, vecs[v].data, 1'b1, 1'b1);
      repeat (3 * vecs[v].clks) @(negedge clk);
      #1;
      check($sformatf("vec%0d_dv", v), 32'(dv_cnt[s] - d0), 32'(vecs[v].exp_dv));
      check($sformatf("vec%0d_fe", v), 32'(fe_cnt[s] - f0), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d_byte", v), 32'(rx_byte[s]), 32'(vecs[v].exp_byte));
      check($sformatf("vec%0d_act_idle", v), 32'(act[s]), 32'd0);
      if (v == 0) begin
        lat = int'((dv_t[0] - start_t) / 10);
        check("latency_in_39_41", 32'(lat >= 39 && lat <= 41), 32'd1);
        check("active_cycles", 32'(act_cyc[0] - a0), 32'd38);
      end
    end

    // Framing error: stop bit low, line held low, then released
    d0 = dv_cnt[1];
    f0 = fe_cnt[1];
    send_frame(1, 8, 8'hF0, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    rx[1] = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("ferr_fe_count", 32'(fe_cnt[1] - f0), 32'd1);
    check("ferr_no_dv", 32'(dv_cnt[1] - d0), 32'd0);
    check("ferr_byte_kept", 32'(rx_byte[1]), 32'h5A);
    check("ferr_act_idle", 32'(act[1]), 32'd0);
    send_frame(1, 8, 8'h81, 1'b1, 1'b1);
    repeat (24) @(negedge clk);
    #1;
    check("after_ferr_dv", 32'(dv_cnt[1] - d0), 32'd1);
    check("after_ferr_byte", 32'(rx_byte[1]), 32'h81);
    check("after_ferr_fe", 32'(fe_cnt[1] - f0), 32'd1);

    // Back-to-back frames with no idle gap
    d0 = dv_cnt[1];
    f0 = fe_cnt[1];
    send_frame(1, 8, 8'h55, 1'b1, 1'b1);
    send_frame(1, 8, 8'h00, 1'b1, 1'b0);
    repeat (24) @(negedge clk);
    #1;
    check("b2b_dv_count", 32'(dv_cnt[1] - d0), 32'd2);
    check("b2b_first", 32'(prev_b[1]), 32'h55);
    check("b2b_second", 32'(last_b[1]), 32'h00);
    check("b2b_fe", 32'(fe_cnt[1] - f0), 32'd0);

    // Glitch: 3-cycle low pulse at 16 clk/bit
    d0 = dv_cnt[2];
    f0 = fe_cnt[2];
    @(negedge clk);
    rx[2] = 1'b0;
    repeat (3) @(negedge clk);
    rx[2] = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("glitch_no_dv", 32'(dv_cnt[2] - d0), 32'd0);
    check("glitch_no_fe", 32'(fe_cnt[2] - f0), 32'd0);
    check("glitch_act_idle", 32'(act[2]), 32'd0);
    send_frame(2, 16, 8'h3C, 1'b1, 1'b1);
    repeat (48) @(negedge clk);
    #1;
    check("post_glitch_dv", 32'(dv_cnt[2] - d0), 32'd1);
    check("post_glitch_byte", 32'(rx_byte[2]), 32'h3C);
    check("post_glitch_fe", 32'(fe_cnt[2] - f0), 32'd0);

    // Reset during data bit 3 at 8 clk/bit
    d0  = dv_cnt[1];
    f0  = fe_cnt[1];
    pat = 8'h6B;
    @(negedge clk);
    rx[1] = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      rx[1] = pat[b];
      repeat (8) @(negedge clk);
    end
    rx[1] = pat[3];
    repeat (4) @(negedge clk);
    #1;
    check("midframe_active", 32'(act[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_dv", 32'(dv[1]), 32'd0);
    check("rst_mid_fe", 32'(fe[1]), 32'd0);
    check("rst_mid_act", 32'(act[1]), 32'd0);
    check("rst_mid_byte", 32'(rx_byte[1]), 32'h00);
    rst   = 1'b0;
    rx[1] = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    check("rst_abort_no_dv", 32'(dv_cnt[1] - d0), 32'd0);
    check("rst_abort_no_fe", 32'(fe_cnt[1] - f0), 32'd0);
    send_frame(1, 8, 8'h7E, 1'b1, 1'b1);
    repeat (24) @(negedge clk);
    #1;
    check("post_rst_dv", 32'(dv_cnt[1] - d0), 32'd1);
    check("post_rst_byte", 32'(rx_byte[1]), 32'h7E);

    // Pulse-shape properties over the whole run
    check("dv_fe_exclusive", 32'(bad_excl), 32'd0);
    check("pulse_width_one", 32'(bad_width), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
